// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the RISC control sequencer.
// Holds the FSM state codes, opcode constants and class boundaries, and the
// instruction-register field positions used by the sequencer and its decoder.
package risc_ctrl_pkg;

  // FSM state codes; code 7 is unused and recovers to StFetch.
  localparam logic [2:0] StFetch     = 3'd0;
  localparam logic [2:0] StDecode    = 3'd1;
  localparam logic [2:0] StRegread   = 3'd2;
  localparam logic [2:0] StExecute   = 3'd3;
  localparam logic [2:0] StMem       = 3'd4;
  localparam logic [2:0] StWriteback = 3'd5;
  localparam logic [2:0] StHalt      = 3'd6;

  // Opcode classes: 0x0-0x7 ALU, 0x8 load, 0x9 store, 0xA-0xE branch, 0xF halt.
  localparam logic [3:0] OpAluLast     = 4'h7;
  localparam logic [3:0] OpLoad        = 4'h8;
  localparam logic [3:0] OpStore       = 4'h9;
  localparam logic [3:0] OpBranchFirst = 4'hA;
  localparam logic [3:0] OpBranchLast  = 4'hE;
  localparam logic [3:0] OpHalt        = 4'hF;

  // Instruction register field positions.
  localparam int unsigned OpcodeMsb = 15;
  localparam int unsigned OpcodeLsb = 12;
  localparam int unsigned FieldDMsb = 11;
  localparam int unsigned FieldDLsb = 9;
  localparam int unsigned FieldAMsb = 8;
  localparam int unsigned FieldALsb = 6;
  localparam int unsigned FieldBMsb = 5;
  localparam int unsigned FieldBLsb = 3;

endpackage

// File: rtl/risc_op_decode.sv
// Combinational opcode classifier for the RISC control sequencer.
// Ports:
//   opcode_i     - IR[15:12]
//   is_alu_o     - ALU class (writes back ALU result)
//   is_load_o    - LOAD
//   is_store_o   - STORE
//   is_branch_o  - BRANCH class
//   is_halt_o    - HALT
module risc_op_decode
  import risc_ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       is_alu_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic       is_halt_o
);

  always_comb begin
    is_alu_o    = (opcode_i <= OpAluLast);
    is_load_o   = (opcode_i == OpLoad);
    is_store_o  = (opcode_i == OpStore);
    is_branch_o = (opcode_i >= OpBranchFirst) && (opcode_i <= OpBranchLast);
    is_halt_o   = (opcode_i == OpHalt);
  end

endmodule

// File: rtl/risc_ctrl_unit.sv
// Multi-cycle control sequencer for the 16-bit RISC core.
// Fetches over a ready-handshaked memory port into the IR, then walks the
// datapath through decode, register read, execute, memory and writeback.
// Ports:
//   I_clk, I_rst        - clock, synchronous active-high reset
//   I_mem_rdata         - memory read data (instruction during fetch)
//   I_mem_ready         - completes the outstanding memory request
//   I_stall             - datapath freeze (honoured outside fetch/mem)
//   O_mem_req, O_mem_we - memory request / store select
//   O_wb_sel            - writeback source: 0 ALU, 1 memory
//   O_regfile_en/_we    - register file enable / write enable
//   O_selA/B/D          - register selects IR[8:6], IR[5:3], IR[11:9]
//   O_alu_en            - ALU enable
//   O_pc_inc/_update    - one-cycle PC strobes
//   O_instr, O_state    - IR and current state
//   O_retired           - retired-instruction counter (mod 2^16)
module risc_ctrl_unit
  import risc_ctrl_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [15:0] I_mem_rdata,
  input  logic        I_mem_ready,
  input  logic        I_stall,
  output logic        O_mem_req,
  output logic        O_mem_we,
  output logic        O_wb_sel,
  output logic        O_regfile_en,
  output logic        O_regfile_we,
  output logic [2:0]  O_selA,
  output logic [2:0]  O_selB,
  output logic [2:0]  O_selD,
  output logic        O_alu_en,
  output logic        O_pc_inc,
  output logic        O_pc_update,
  output logic [15:0] O_instr,
  output logic [2:0]  O_state,
  output logic [15:0] O_retired
);

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] retired_q, retired_d;

  logic is_alu, is_load, is_store, is_branch, is_halt;
  logic retire;
  logic mem_req, mem_we, wb_sel, rf_en, rf_we, alu_en, pc_inc, pc_update;

  risc_op_decode u_op_decode (
    .opcode_i    (ir_q[OpcodeMsb:OpcodeLsb]),
    .is_alu_o    (is_alu),
    .is_load_o   (is_load),
    .is_store_o  (is_store),
    .is_branch_o (is_branch),
    .is_halt_o   (is_halt)
  );

  // Next state and strobes. A stall simply withholds the advancing branch of
  // each stallable state, which also suppresses its strobes and any retire.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    wb_sel    = 1'b0;
    rf_en     = 1'b0;
    rf_we     = 1'b0;
    alu_en    = 1'b0;
    pc_inc    = 1'b0;
    pc_update = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (I_mem_ready) begin
          ir_d    = I_mem_rdata;
          pc_inc  = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!I_stall) state_d = is_halt ? StHalt : StRegread;
      end
      StRegread: begin
        if (!I_stall) begin
          rf_en   = 1'b1;
          state_d = StExecute;
        end
      end
      StExecute: begin
        if (!I_stall) begin
          alu_en = 1'b1;
          if (is_alu) begin
            state_d = StWriteback;
          end else if (is_load || is_store) begin
            state_d = StMem;
          end else begin
            pc_update = is_branch;
            retire    = is_branch;
            state_d   = StFetch;
          end
        end
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (I_mem_ready) begin
          retire  = is_store;
          state_d = is_store ? StFetch : StWriteback;
        end
      end
      StWriteback: begin
        wb_sel = is_load;
        if (!I_stall) begin
          rf_en   = 1'b1;
          rf_we   = 1'b1;
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
    retired_d = retired_q + {15'd0, retire};
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Reset blanks every output combinationally, including in the first reset cycle.
  always_comb begin
    O_mem_req    = mem_req & ~I_rst;
    O_mem_we     = mem_we & ~I_rst;
    O_wb_sel     = wb_sel & ~I_rst;
    O_regfile_en = rf_en & ~I_rst;
    O_regfile_we = rf_we & ~I_rst;
    O_alu_en     = alu_en & ~I_rst;
    O_pc_inc     = pc_inc & ~I_rst;
    O_pc_update  = pc_update & ~I_rst;
    O_selA       = I_rst ? 3'd0 : ir_q[FieldAMsb:FieldALsb];
    O_selB       = I_rst ? 3'd0 : ir_q[FieldBMsb:FieldBLsb];
    O_selD       = I_rst ? 3'd0 : ir_q[FieldDMsb:FieldDLsb];
    O_instr      = I_rst ? 16'd0 : ir_q;
    O_state      = I_rst ? 3'd0 : state_q;
    O_retired    = I_rst ? 16'd0 : retired_q;
  end

endmodule

// File: tb/tb_risc_ctrl_unit.sv
// Self-checking bench for risc_ctrl_unit. The stimulus tasks push one expected
// record per clock cycle; a negedge monitor pops and compares each record.
module tb_risc_ctrl_unit;

  localparam logic [2:0] SFetch = 3'd0;
  localparam logic [2:0] SDecode = 3'd1;
  localparam logic [2:0] SRegread = 3'd2;
  localparam logic [2:0] SExecute = 3'd3;
  localparam logic [2:0] SMem = 3'd4;
  localparam logic [2:0] SWb = 3'd5;
  localparam logic [2:0] SHalt = 3'd6;
  localparam logic [2:0] SNone = 3'd7;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic [15:0] I_mem_rdata;
  logic        I_mem_ready;
  logic        I_stall;
  logic        O_mem_req, O_mem_we, O_wb_sel, O_regfile_en, O_regfile_we;
  logic [2:0]  O_selA, O_selB, O_selD;
  logic        O_alu_en, O_pc_inc, O_pc_update;
  logic [15:0] O_instr;
  logic [2:0]  O_state;
  logic [15:0] O_retired;

  always #5 I_clk = ~I_clk;

  risc_ctrl_unit dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_mem_rdata  (I_mem_rdata),
    .I_mem_ready  (I_mem_ready),
    .I_stall      (I_stall),
    .O_mem_req    (O_mem_req),
    .O_mem_we     (O_mem_we),
    .O_wb_sel     (O_wb_sel),
    .O_regfile_en (O_regfile_en),
    .O_regfile_we (O_regfile_we),
    .O_selA       (O_selA),
    .O_selB       (O_selB),
    .O_selD       (O_selD),
    .O_alu_en     (O_alu_en),
    .O_pc_inc     (O_pc_inc),
    .O_pc_update  (O_pc_update),
    .O_instr      (O_instr),
    .O_state      (O_state),
    .O_retired    (O_retired)
  );

  // strobes = {mem_req, mem_we, wb_sel, rf_en, rf_we, alu_en, pc_inc, pc_update}
  typedef struct packed {
    logic [2:0]  state;
    logic [7:0]  strobes;
    logic [15:0] retired;
    logic [15:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_ir = '0;
  logic [15:0] exp_retired = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  always @(negedge I_clk) begin
    exp_t e;
    logic [15:0] ei;
    if (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      ei = e.instr;
      check("state", 32'(O_state), 32'(e.state));
      check("strobes", 32'({O_mem_req, O_mem_we, O_wb_sel, O_regfile_en, O_regfile_we,
                            O_alu_en, O_pc_inc, O_pc_update}), 32'(e.strobes));
      check("retired", 32'(O_retired), 32'(e.retired));
      check("instr", 32'(O_instr), 32'(ei));
      check("sels", 32'({O_selD, O_selA, O_selB}), 32'({ei[11:9], ei[8:6], ei[5:3]}));
    end
  end

  // Expected strobes for one cycle in state st, taken from the operation table.
  function automatic exp_t mk(input logic [2:0] st, input bit stalled, input bit adv,
                              input bit ld, input bit sto, input bit br);
    exp_t e;
    logic mreq, mwe, wsel, ren, rwe, aen, pinc, pupd;
    {mreq, mwe, wsel, ren, rwe, aen, pinc, pupd} = 8'd0;
    case (st)
      SFetch:   begin mreq = 1'b1; pinc = adv; end
      SRegread: ren = !stalled;
      SExecute: begin aen = !stalled; pupd = br && !stalled; end
      SMem:     begin mreq = 1'b1; mwe = sto; end
      SWb:      begin ren = !stalled; rwe = !stalled; wsel = ld; end
      default:  ;
    endcase
    e.state   = st;
    e.strobes = {mreq, mwe, wsel, ren, rwe, aen, pinc, pupd};
    e.retired = exp_retired;
    e.instr   = exp_ir;
    return e;
  endfunction

  task automatic step(input logic rdy, input logic stl, input exp_t e);
    I_mem_ready = rdy;
    I_stall     = stl;
    sb_q.push_back(e);
    @(posedge I_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    I_rst = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    exp_ir      = '0;
    exp_retired = '0;
    I_rst       = 1'b0;
  endtask

  task automatic idle_fetch();
    step(1'b0, 1'b0, mk(SFetch, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic phase(input logic [2:0] s, input logic [2:0] stall_st, input int stall_len,
                       input bit ld, input bit sto, input bit br);
    if (s == stall_st)
      for (int i = 0; i < stall_len; i++) step(1'b0, 1'b1, mk(s, 1'b1, 1'b0, ld, sto, br));
    step(1'b0, 1'b0, mk(s, 1'b0, 1'b1, ld, sto, br));
  endtask

  task automatic run_instr(input logic [15:0] instr, input int mem_wait,
                           input logic [2:0] stall_st, input int stall_len);
    logic [3:0] op;
    bit ld, sto, br, hl;
    op  = instr[15:12];
    ld  = (op == 4'h8);
    sto = (op == 4'h9);
    br  = (op >= 4'hA) && (op <= 4'hE);
    hl  = (op == 4'hF);
    I_mem_rdata = instr;
    step(1'b1, stall_st == SFetch, mk(SFetch, 1'b0, 1'b1, ld, sto, br));
    exp_ir = instr;
    phase(SDecode, stall_st, stall_len, ld, sto, br);
    if (hl) begin
      // Halt holds regardless of stall or ready activity.
      for (int i = 0; i < 20; i++)
        step(i[0], i[1], mk(SHalt, 1'b0, 1'b0, ld, sto, br));
      return;
    end
    phase(SRegread, stall_st, stall_len, ld, sto, br);
    phase(SExecute, stall_st, stall_len, ld, sto, br);
    if (br) begin
      exp_retired++;
      return;
    end
    if (ld || sto) begin
      for (int i = 0; i < mem_wait; i++)
        step(1'b0, stall_st == SMem, mk(SMem, 1'b0, 1'b0, ld, sto, br));
      step(1'b1, stall_st == SMem, mk(SMem, 1'b0, 1'b1, ld, sto, br));
      if (sto) begin
        exp_retired++;
        return;
      end
    end
    phase(SWb, stall_st, stall_len, ld, sto, br);
    exp_retired++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    I_rst       = 1'b1;
    I_mem_ready = 1'b0;
    I_stall     = 1'b0;
    I_mem_rdata = '0;
    @(posedge I_clk);
    #1;
    do_reset(2);

    run_instr(16'h1A98, 0, SNone, 0);      // ALU: selD=5 selA=2 selB=3
    run_instr(16'h8123, 3, SNone, 0);      // LOAD, 3 wait cycles in MEM
    run_instr(16'hC000, 0, SNone, 0);      // BRANCH
    run_instr(16'h9456, 1, SMem, 0);       // STORE, stall ignored in MEM
    run_instr(16'h2ABC, 0, SRegread, 2);   // ALU, 2-cycle stall in REGREAD
    run_instr(16'h7FFF, 0, SWb, 1);        // ALU, stall in WRITEBACK
    run_instr(16'h8E07, 0, SDecode, 1);    // LOAD, stall in DECODE
    run_instr(16'hA5A5, 0, SExecute, 3);   // BRANCH, stall in EXECUTE
    run_instr(16'h3C71, 0, SFetch, 0);     // ALU, stall ignored in FETCH

    // Preload the retire counter to its maximum, then retire one to wrap.
    idle_fetch();
    force dut.retired_q = 16'hFFFF;
    exp_retired = 16'hFFFF;
    idle_fetch();
    release dut.retired_q;
    run_instr(16'hE001, 0, SNone, 0);

    run_instr(16'h0249, 0, SNone, 0);
    run_instr(16'hF000, 0, SNone, 0);      // HALT holds 20 cycles
    do_reset(1);
    run_instr(16'h5DB6, 0, SNone, 0);

    // Reset while a fetch is pending: no pulse, no retire.
    idle_fetch();
    do_reset(1);
    run_instr(16'h9001, 2, SNone, 0);

    @(negedge I_clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
